dac_serial_sched: RTL and testbench

//  Serial-link scheduler for the audio DAC path. Shares one serial link (sclk/cs_n/sdo)

---
 rtl/dac_serial_sched.sv | 159 +++++++++++++++
 tb/tb_dac_serial_sched.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_serial_sched.sv
// Shares one serial DAC link between a sample stream (A) and config writes (B):
// round-robin grant, ack pulse, CS-framed MSB-first word, fixed inter-frame gap.
module dac_serial_sched #(
  parameter int DIV_HALF = 2,
  parameter int WORD_W   = 16,
  parameter int IDLE_GAP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic [WORD_W-1:0] data_a,
  output logic              ack_a,
  input  logic              req_b,
  input  logic [WORD_W-1:0] data_b,
  output logic              ack_b,
  output logic              sclk,
  output logic              cs_n,
  output logic              sdo,
  output logic              busy,
  output logic              frame_done
);

  localparam int DIV_W   = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam int CNT_MAX = (WORD_W > 2 * IDLE_GAP) ? WORD_W : 2 * IDLE_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV_HALF - 1);
  localparam logic [CNT_W-1:0] BITS_LAST = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(2 * IDLE_GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_SHIFT, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              last_b_q, last_b_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              sdo_q, sdo_d;
  logic              ack_a_q, ack_a_d;
  logic              ack_b_q, ack_b_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tick;
  logic              grant_a;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    last_b_d = last_b_q;
    sclk_d   = sclk_q;
    cs_n_d   = cs_n_q;
    sdo_d    = sdo_q;
    busy_d   = busy_q;
    ack_a_d  = 1'b0;
    ack_b_d  = 1'b0;
    done_d   = 1'b0;
    grant_a  = 1'b0;
    tick     = (state_q != S_IDLE) && (div_q == DIV_LAST);
    div_d    = (state_q == S_IDLE || tick) ? '0 : div_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (req_a || req_b) begin
          // On a tie the requester that did not win last time goes first.
          grant_a  = req_a && (!req_b || last_b_q);
          shreg_d  = grant_a ? data_a : data_b;
          sdo_d    = grant_a ? data_a[WORD_W-1] : data_b[WORD_W-1];
          last_b_d = !grant_a;
          ack_a_d  = grant_a;
          ack_b_d  = !grant_a;
          busy_d   = 1'b1;
          cs_n_d   = 1'b0;
          sclk_d   = 1'b0;
          cnt_d    = '0;
          state_d  = S_LEAD;
        end
      end
      S_LEAD: begin
        if (tick) begin
          sclk_d  = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (tick) begin
          if (sclk_q) begin
            // Falling edge: present the next bit (zeros after the last one).
            sclk_d  = 1'b0;
            shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
            sdo_d   = shreg_q[WORD_W-2];
          end else if (cnt_q == BITS_LAST) begin
            cs_n_d  = 1'b1;
            sdo_d   = 1'b0;
            cnt_d   = '0;
            state_d = S_GAP;
          end else begin
            sclk_d = 1'b1;
            cnt_d  = cnt_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          if (cnt_q == GAP_LAST) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      cnt_q    <= '0;
      shreg_q  <= '0;
      last_b_q <= 1'b1;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      sdo_q    <= 1'b0;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      last_b_q <= last_b_d;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
      sdo_q    <= sdo_d;
      ack_a_q  <= ack_a_d;
      ack_b_q  <= ack_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ack_a      = ack_a_q;
  assign ack_b      = ack_b_q;
  assign sclk       = sclk_q;
  assign cs_n       = cs_n_q;
  assign sdo        = sdo_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_dac_serial_sched.sv
// Bench for dac_serial_sched: frame-timeline reference model, vector table,
// corner-case sequences, random traffic, and a small-parameter instance.
module tb_dac_serial_sched;
  localparam int W  = 16;
  localparam int DH = 2;
  localparam int IG = 2;
  localparam int L  = (2 * W + 1) * DH;  // cs_n low cycles per frame
  localparam int G  = 2 * IG * DH;       // gap cycles before frame_done

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic req_a = 1'b0, req_b = 1'b0;
  logic [W-1:0] data_a = '0, data_b = '0;
  logic ack_a, ack_b, sclk, cs_n, sdo, busy, frame_done;

  logic s_req_a = 1'b0, s_req_b = 1'b0;
  logic [7:0] s_data_a = '0, s_data_b = '0;
  logic s_ack_a, s_ack_b, s_sclk, s_cs_n, s_sdo, s_busy, s_frame_done;

  always #5 clk = ~clk;

  dac_serial_sched #(.DIV_HALF(DH), .WORD_W(W), .IDLE_GAP(IG)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
    .sclk(sclk), .cs_n(cs_n), .sdo(sdo), .busy(busy), .frame_done(frame_done)
  );

  dac_serial_sched #(.DIV_HALF(1), .WORD_W(8), .IDLE_GAP(1)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .req_a(s_req_a), .data_a(s_data_a), .ack_a(s_ack_a),
    .req_b(s_req_b), .data_b(s_data_b), .ack_b(s_ack_b),
    .sclk(s_sclk), .cs_n(s_cs_n), .sdo(s_sdo), .busy(s_busy), .frame_done(s_frame_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic checkv(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a grant at edge g fixes the whole frame timeline.
  int           cyc = 0;
  int           g_edge = -1;
  bit           g_is_a = 1'b0;
  logic [W-1:0] g_word = '0;
  bit           m_last_b = 1'b1;
  logic         prev_sclk = 1'b0, prev_cs_n = 1'b1;
  logic [W-1:0] cap_word = '0;
  int           cap_bits = 0;
  int           last_rise = -1;
  int           frames_done = 0;
  logic [W-1:0] last_frame = '0;

  task automatic model_reset();
    g_edge    = -1;
    m_last_b  = 1'b1;
    prev_cs_n = 1'b1;
    prev_sclk = 1'b0;
    cap_bits  = 0;
    cap_word  = '0;
    last_rise = -1;
  endtask

  task automatic step();
    int n;
    int d;
    bit ga;
    n = cyc + 1;
    if (rst_n && (req_a || req_b) && (g_edge < 0 || n >= g_edge + L + G + 1)) begin
      ga       = req_a && (!req_b || m_last_b);
      m_last_b = !ga;
      g_is_a   = ga;
      g_word   = ga ? data_a : data_b;
      g_edge   = n;
    end
    @(posedge clk);
    cyc = n;
    #1;
    d = (g_edge < 0) ? -1 : cyc - g_edge;
    check1("ack_a", ack_a, (d == 0) && g_is_a);
    check1("ack_b", ack_b, (d == 0) && !g_is_a);
    check1("cs_n", cs_n, !(d >= 0 && d < L));
    check1("busy", busy, d >= 0 && d < L + G);
    check1("frame_done", frame_done, d == L + G);
    if (!cs_n) begin
      if (prev_cs_n) begin
        cap_bits  = 0;
        cap_word  = '0;
        last_rise = -1;
      end
      if (sclk && !prev_sclk) begin
        if (last_rise >= 0) checkv("sclk_period", cyc - last_rise, 2 * DH);
        last_rise = cyc;
        cap_word  = {cap_word[W-2:0], sdo};
        cap_bits++;
      end
    end else begin
      check1("sclk_idle", sclk, 1'b0);
      check1("sdo_idle", sdo, 1'b0);
      if (!prev_cs_n) begin
        checkv("frame_bits", cap_bits, W);
        checkv("frame_word", 32'(cap_word), 32'(g_word));
        frames_done++;
        last_frame = cap_word;
        $display("frame %0d: %s word=%h expected=%h bits=%0d", frames_done,
                 g_is_a ? "A" : "B", cap_word, g_word, cap_bits);
      end
    end
    prev_sclk = sclk;
    prev_cs_n = cs_n;
  endtask

  task automatic wait_ack(input int bound, output bit got, output bit was_a);
    got   = 1'b0;
    was_a = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      step();
      if (ack_a || ack_b) begin
        got   = 1'b1;
        was_a = ack_a;
      end
    end
  endtask

  task automatic wait_done(input int bound, output bit got);
    got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      step();
      if (frame_done) got = 1'b1;
    end
  endtask

  typedef struct {
    logic         ra;
    logic         rb;
    logic [W-1:0] da;
    logic [W-1:0] db;
    logic         exp_a;
    logic [W-1:0] exp_word;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit got, wa, gd, seen_done;
    int f0;
    int s_ack_cyc, s_low, s_bits, s_gap, s_last_rise;
    logic [7:0] s_word;
    bit s_done;
    logic s_prev_sclk;

    vecs[0] = '{1'b1, 1'b0, 16'hA5C3, 16'h0000, 1'b1, 16'hA5C3};
    vecs[1] = '{1'b1, 1'b1, 16'h1111, 16'h2222, 1'b0, 16'h2222};
    vecs[2] = '{1'b1, 1'b1, 16'h1111, 16'h2222, 1'b1, 16'h1111};
    vecs[3] = '{1'b0, 1'b1, 16'h0000, 16'h8001, 1'b0, 16'h8001};
    vecs[4] = '{1'b1, 1'b1, 16'hFFFF, 16'h0001, 1'b1, 16'hFFFF};
    vecs[5] = '{1'b1, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0001};
    vecs[6] = '{1'b0, 1'b1, 16'h1234, 16'h7FFE, 1'b0, 16'h7FFE};
    vecs[7] = '{1'b1, 1'b1, 16'hDEAD, 16'hBEEF, 1'b1, 16'hDEAD};

    // Power-on reset and reset-state check
    #2 rst_n = 1'b0;
    #1;
    check1("rst0_sclk", sclk, 1'b0);
    check1("rst0_cs_n", cs_n, 1'b1);
    check1("rst0_sdo", sdo, 1'b0);
    check1("rst0_busy", busy, 1'b0);
    check1("rst0_done", frame_done, 1'b0);
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    step();

    // Vector table: one request set per record from idle
    for (int i = 0; i < 8; i++) begin
      req_a  = vecs[i].ra;
      req_b  = vecs[i].rb;
      data_a = vecs[i].da;
      data_b = vecs[i].db;
      f0 = frames_done;
      wait_ack(200, got, wa);
      req_a = 1'b0;
      req_b = 1'b0;
      check1("vec_ack_seen", got, 1'b1);
      check1("vec_winner_a", wa, vecs[i].exp_a);
      wait_done(200, gd);
      check1("vec_done_seen", gd, 1'b1);
      checkv("vec_frames", frames_done - f0, 1);
      checkv("vec_word", 32'(last_frame), 32'(vecs[i].exp_word));
      $display("vec %0d: ack=%s word=%h expected=%h", i, wa ? "A" : "B", last_frame, vecs[i].exp_word);
    end

    // Data change right after ack must not affect the frame
    req_a = 1'b1;
    data_a = 16'hA5C3;
    wait_ack(200, got, wa);
    req_a = 1'b0;
    data_a = 16'hFFFF;
    wait_done(200, gd);
    checkv("data_hold_word", 32'(last_frame), 32'hA5C3);
    $display("data-hold: word=%h expected=a5c3", last_frame);

    // Reset in the middle of SHIFT (sclk high at this point)
    req_a = 1'b1;
    data_a = 16'h5A5A;
    wait_ack(200, got, wa);
    req_a = 1'b0;
    for (int i = 0; i < 22; i++) step();
    rst_n = 1'b0;
    #1;
    check1("rstmid_sclk", sclk, 1'b0);
    check1("rstmid_cs_n", cs_n, 1'b1);
    check1("rstmid_sdo", sdo, 1'b0);
    check1("rstmid_busy", busy, 1'b0);
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    $display("mid-frame reset applied");

    // Both held: strict alternation starting with A after reset
    req_a = 1'b1;
    req_b = 1'b1;
    data_a = 16'h1111;
    data_b = 16'h2222;
    for (int k = 0; k < 4; k++) begin
      wait_ack(200, got, wa);
      check1("alt_ack_seen", got, 1'b1);
      check1("alt_winner_a", wa, (k % 2) == 0);
      $display("alternation %0d: ack=%s", k, wa ? "A" : "B");
    end
    req_a = 1'b0;
    req_b = 1'b0;
    wait_done(200, gd);
    checkv("alt_last_word", 32'(last_frame), 32'h2222);

    // req_b held, req_a raised during B's SHIFT: A waits for frame_done, then wins
    req_b = 1'b1;
    data_b = 16'h0F0F;
    wait_ack(200, got, wa);
    check1("ab_first_b", wa, 1'b0);
    for (int i = 0; i < 20; i++) step();
    req_a = 1'b1;
    data_a = 16'h1357;
    seen_done = 1'b0;
    got = 1'b0;
    wa = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      step();
      if (frame_done) seen_done = 1'b1;
      if (ack_a || ack_b) begin
        got = 1'b1;
        wa = ack_a;
      end
    end
    req_a = 1'b0;
    req_b = 1'b0;
    check1("ab_ack_seen", got, 1'b1);
    check1("ab_winner_a", wa, 1'b1);
    check1("ab_after_done", seen_done, 1'b1);
    wait_done(200, gd);
    checkv("ab_word", 32'(last_frame), 32'h1357);
    $display("late A: ack=%s word=%h expected=1357", wa ? "A" : "B", last_frame);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step();
      if (req_a && ack_a) req_a = 1'($urandom_range(0, 1));
      else if (!req_a) req_a = ($urandom_range(0, 7) == 0);
      if (req_b && ack_b) req_b = 1'($urandom_range(0, 1));
      else if (!req_b) req_b = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) data_a = W'($urandom);
      if ($urandom_range(0, 3) == 0) data_b = W'($urandom);
    end
    req_a = 1'b0;
    req_b = 1'b0;
    for (int i = 0; i < 100; i++) step();

    // Small instance: DIV_HALF=1, WORD_W=8, IDLE_GAP=1
    s_ack_cyc = -1;
    s_low = 0;
    s_bits = 0;
    s_gap = 0;
    s_last_rise = -1;
    s_word = '0;
    s_done = 1'b0;
    s_prev_sclk = 1'b0;
    s_req_a = 1'b1;
    s_data_a = 8'h81;
    for (int i = 1; i <= 60 && !s_done; i++) begin
      @(posedge clk);
      #1;
      if (s_ack_a) begin
        s_ack_cyc = i;
        s_req_a = 1'b0;
        s_data_a = 8'h00;
      end
      if (!s_cs_n) begin
        s_low++;
        if (s_sclk && !s_prev_sclk) begin
          if (s_last_rise >= 0) checkv("s_sclk_period", i - s_last_rise, 2);
          s_last_rise = i;
          s_word = {s_word[6:0], s_sdo};
          s_bits++;
        end
      end else if (s_frame_done) begin
        s_done = 1'b1;
      end else if (s_low > 0) begin
        s_gap++;
      end
      s_prev_sclk = s_sclk;
    end
    checkv("s_ack_cycle", s_ack_cyc, 1);
    checkv("s_cs_low", s_low, 17);
    checkv("s_bits", s_bits, 8);
    checkv("s_word", 32'(s_word), 32'h81);
    checkv("s_gap", s_gap, 2);
    check1("s_done_seen", s_done, 1'b1);
    $display("small: word=%h low=%0d gap=%0d bits=%0d", s_word, s_low, s_gap, s_bits);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
